// File: rtl/me_control_if.sv
// me_control_if: handshake and PE-array control bundle of the motion-estimator control unit.
// master: control unit side; takes start, drives addresses, PE strobes, comparator strobe/vector, busy, completed.
// slave: consumer side (top / PE array / comparator); drives start, observes everything else.
interface me_control_if;
    logic        start;
    logic [7:0]  AddressR;
    logic [9:0]  AddressS1;
    logic [9:0]  AddressS2;
    logic [15:0] S1S2mux;
    logic [15:0] NewDist;
    logic [15:0] PEready;
    logic        CompStart;
    logic [3:0]  VectorX;
    logic [3:0]  VectorY;
    logic        busy;
    logic        completed;
    modport master (
        input  start,
        output AddressR, AddressS1, AddressS2, S1S2mux, NewDist, PEready,
               CompStart, VectorX, VectorY, busy, completed
    );
    modport slave (
        output start,
        input  AddressR, AddressS1, AddressS2, S1S2mux, NewDist, PEready,
               CompStart, VectorX, VectorY, busy, completed
    );
endinterface

// File: rtl/me_control.sv
// me_control: sequences a 16x16 full-search block match over a 32-pitch search memory.
// Ports: clock, reset (sync, active-high), bus (me_control_if.master: start in; addresses,
// PE select/clear/valid strobes, comparator strobe with candidate vector, busy, completed out).
module me_control (
    input  logic         clock,
    input  logic         reset,
    me_control_if.master bus
);
    localparam logic [1:0]  IDLE = 2'd0;
    localparam logic [1:0]  RUN  = 2'd1;
    localparam logic [1:0]  DONE = 2'd2;
    localparam logic [12:0] LAST = 13'd4111;

    logic [1:0]  state;
    logic [12:0] count;
    logic [3:0]  y, i, j;
    logic [4:0]  row;
    logic [15:0] hit;
    logic        run, drain, comp;

    always_ff @(posedge clock) begin
        if (reset) begin
            state <= IDLE;
            count <= '0;
        end else begin
            case (state)
                IDLE: begin
                    state <= bus.start ? RUN : IDLE;
                    count <= '0;
                end
                RUN: begin
                    state <= (count == LAST) ? DONE : RUN;
                    count <= (count == LAST) ? count : count + 13'd1;
                end
                DONE: begin
                    state <= bus.start ? DONE : IDLE;
                    count <= bus.start ? count : '0;
                end
                default: begin
                    state <= IDLE;
                    count <= '0;
                end
            endcase
        end
    end

    assign y     = count[11:8];
    assign i     = count[7:4];
    assign j     = count[3:0];
    assign run   = state == RUN;
    // Results exist only once the first 256-cycle block pass has filled the PEs.
    assign drain = run && (count[12:8] != '0);
    assign row   = {1'b0, y} + {1'b0, i};

    genvar k;
    generate
        for (k = 0; k < 16; k++) begin : g_pe
            assign hit[k]         = count[7:0] == 8'(k);
            assign bus.S1S2mux[k] = run && (j >= 4'(k));
        end
    endgenerate

    assign comp          = drain && (hit != '0);
    // (y+i)*32 + j with j < 16, so bit 4 is free: 0 selects S1, 1 adds the +16 for S2.
    assign bus.AddressR  = run ? count[7:0] : '0;
    assign bus.AddressS1 = run ? {row, 1'b0, j} : '0;
    assign bus.AddressS2 = run ? {row, 1'b1, j} : '0;
    assign bus.NewDist   = run ? hit : '0;
    assign bus.PEready   = drain ? hit : '0;
    assign bus.CompStart = comp;
    assign bus.VectorX   = comp ? j : '0;
    // Results lag the scan by one block row, hence y-1 (wrapping to 15 in the tail).
    assign bus.VectorY   = comp ? y - 4'd1 : '0;
    assign bus.busy      = run;
    assign bus.completed = state == DONE;
endmodule

// File: tb/tb_me_control.sv
module tb_me_control;
    logic clock = 1'b0;
    logic reset = 1'b1;
    int tests = 0;
    int fails = 0;

    me_control_if bus();
    me_control dut (.clock(clock), .reset(reset), .bus(bus.master));

    always #5 clock = ~clock;

    typedef struct packed {
        logic [7:0]  ar;
        logic [9:0]  s1;
        logic [9:0]  s2;
        logic [15:0] mux;
        logic [15:0] nd;
        logic [15:0] pr;
        logic        cs;
        logic [3:0]  vx;
        logic [3:0]  vy;
        logic        busy;
        logic        done;
    } outs_t;

    outs_t obs, exp_o;
    int m_state = 0;
    int m_cnt = 0;

    assign obs = {bus.AddressR, bus.AddressS1, bus.AddressS2, bus.S1S2mux, bus.NewDist,
                  bus.PEready, bus.CompStart, bus.VectorX, bus.VectorY, bus.busy, bus.completed};

    // Reference: phase 0 idle, 1 run, 2 done; m_cnt is the cycle index within the run.
    always @(posedge clock) begin
        if (reset) begin
            m_state = 0;
            m_cnt = 0;
        end else if (m_state == 0) begin
            if (bus.start) m_state = 1;
            m_cnt = 0;
        end else if (m_state == 1) begin
            if (m_cnt == 4111) m_state = 2;
            else m_cnt = m_cnt + 1;
        end else if (!bus.start) begin
            m_state = 0;
            m_cnt = 0;
        end
    end

    function automatic outs_t model_out(int st, int c);
        outs_t o;
        int y, i, j, lo;
        o = '0;
        y = (c / 256) % 16;
        i = (c / 16) % 16;
        j = c % 16;
        lo = c % 256;
        o.done = st == 2;
        if (st == 1) begin
            o.busy = 1'b1;
            o.ar = 8'(lo);
            o.s1 = 10'((y + i) * 32 + j);
            o.s2 = 10'((y + i) * 32 + j + 16);
            for (int k = 0; k < 16; k++) begin
                o.mux[k] = j >= k;
                o.nd[k] = lo == k;
                o.pr[k] = (lo == k) && (c >= 256);
            end
            o.cs = o.pr != 0;
            if (o.cs) begin
                o.vx = 4'(j);
                o.vy = 4'((y + 15) % 16);
            end
        end
        return o;
    endfunction

    assign exp_o = model_out(m_state, m_cnt);

    // Walks one run from its count-0 cycle, comparing every cycle to the model and
    // hitting the fixed decode points; returns busy and CompStart cycle totals.
    task automatic run_checked(input string tag, output int busy_n, output int cs_n);
        int n = 0;
        busy_n = 0;
        cs_n = 0;
        while (bus.busy === 1'b1 && n < 5000) begin
            busy_n++;
            cs_n += int'(bus.CompStart);
            tests++;
            if (obs !== exp_o)
                $display("FAIL %s_trace n=%0d got %h exp %h", tag, n, obs, exp_o);
            if (obs !== exp_o) fails++;
            if (n == 'h123) begin
                tests++;
                if ({obs.ar, obs.s1, obs.s2, obs.mux} !== {8'h23, 10'd99, 10'd115, 16'h000F}) begin
                    fails++;
                    $display("FAIL %s_addr_123 got %h/%0d/%0d/%h exp 23/99/115/000f", tag, obs.ar, obs.s1, obs.s2, obs.mux);
                end
            end
            if (n == 'hFFF) begin
                tests++;
                if ({obs.s1, obs.s2} !== {10'd975, 10'd991}) begin
                    fails++;
                    $display("FAIL %s_addr_fff got %0d/%0d exp 975/991", tag, obs.s1, obs.s2);
                end
            end
            if (n == 256) begin
                tests++;
                if ({obs.pr, obs.nd, obs.cs, obs.vx, obs.vy} !== {16'h0001, 16'h0001, 1'b1, 4'd0, 4'd0}) begin
                    fails++;
                    $display("FAIL %s_strobe_256 got pr=%h nd=%h cs=%b v=%0d,%0d exp 0001 0001 1 0,0", tag, obs.pr, obs.nd, obs.cs, obs.vx, obs.vy);
                end
            end
            if (n == 'h52A) begin
                tests++;
                if ({obs.pr, obs.nd, obs.cs} !== 33'd0) begin
                    fails++;
                    $display("FAIL %s_strobe_52a got pr=%h nd=%h cs=%b exp 0 0 0", tag, obs.pr, obs.nd, obs.cs);
                end
            end
            if (n == 4111) begin
                tests++;
                if ({obs.pr, obs.cs, obs.vx, obs.vy} !== {16'h8000, 1'b1, 4'd15, 4'd15}) begin
                    fails++;
                    $display("FAIL %s_strobe_4111 got pr=%h cs=%b v=%0d,%0d exp 8000 1 15,15", tag, obs.pr, obs.cs, obs.vx, obs.vy);
                end
            end
            n++;
            @(negedge clock);
        end
        tests++;
        if (busy_n != 4112) begin
            fails++;
            $display("FAIL %s_busy_len got %0d exp 4112", tag, busy_n);
        end
        tests++;
        if (cs_n != 256) begin
            fails++;
            $display("FAIL %s_compstart_count got %0d exp 256", tag, cs_n);
        end
        tests++;
        if (bus.completed !== 1'b1) begin
            fails++;
            $display("FAIL %s_completed_rise got %b exp 1", tag, bus.completed);
        end
    endtask

    task automatic test_reset;
        reset = 1'b1;
        bus.start = 1'b1;
        repeat (3) begin
            @(posedge clock);
            @(negedge clock);
            tests++;
            if (obs !== '0) begin
                fails++;
                $display("FAIL reset_outputs got %h exp 0", obs);
            end
        end
        reset = 1'b0;
        @(negedge clock);
        tests++;
        if (bus.busy !== 1'b1 || bus.AddressS1 !== 10'd0 || bus.completed !== 1'b0) begin
            fails++;
            $display("FAIL reset_release busy=%b s1=%0d done=%b exp 1 0 0", bus.busy, bus.AddressS1, bus.completed);
        end
    endtask

    task automatic test_full_run;
        int b, c;
        run_checked("full", b, c);
        for (int t = 0; t < 100; t++) begin
            tests++;
            if (bus.completed !== 1'b1 || bus.busy !== 1'b0 || obs !== exp_o) begin
                fails++;
                $display("FAIL done_hold t=%0d got %h exp %h", t, obs, exp_o);
            end
            @(negedge clock);
        end
    endtask

    task automatic test_restart;
        int b, c;
        bus.start = 1'b0;
        @(negedge clock);
        tests++;
        if (obs !== '0) begin
            fails++;
            $display("FAIL restart_idle got %h exp 0", obs);
        end
        bus.start = 1'b1;
        @(negedge clock);
        tests++;
        if (bus.busy !== 1'b1 || bus.AddressS1 !== 10'd0) begin
            fails++;
            $display("FAIL restart_begin busy=%b s1=%0d exp 1 0", bus.busy, bus.AddressS1);
        end
        run_checked("restart", b, c);
    endtask

    task automatic test_reset_mid_run;
        int b, c;
        bus.start = 1'b0;
        @(negedge clock);
        bus.start = 1'b1;
        @(negedge clock);
        repeat (2000) @(negedge clock);
        tests++;
        if (bus.AddressR !== 8'hD0 || bus.busy !== 1'b1) begin
            fails++;
            $display("FAIL midrun_at_2000 ar=%h busy=%b exp d0 1", bus.AddressR, bus.busy);
        end
        reset = 1'b1;
        @(negedge clock);
        tests++;
        if (obs !== '0) begin
            fails++;
            $display("FAIL midrun_reset got %h exp 0", obs);
        end
        reset = 1'b0;
        @(negedge clock);
        run_checked("after_reset", b, c);
    endtask

    task automatic test_random;
        for (int r = 0; r < 3; r++) begin
            for (int t = 0; t < 4500; t++) begin
                bus.start = $urandom_range(0, 3) != 0;
                reset = $urandom_range(0, 2999) == 0;
                @(negedge clock);
                tests++;
                if (obs !== exp_o) begin
                    fails++;
                    $display("FAIL random r=%0d t=%0d got %h exp %h", r, t, obs, exp_o);
                end
            end
        end
        reset = 1'b0;
    endtask

    initial begin
        bus.start = 1'b0;
        test_reset();
        test_full_run();
        test_restart();
        test_reset_mid_run();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/me_control.md
# me_control

Control unit for the motion-estimator core. It sequences a full-search block match of a 16x16 reference block R against a 31x31 search window S stored as a 32x32 memory. It drives the R and S memory addresses (AddressR, AddressS1, AddressS2), the per-PE S1/S2 select, accumulator-clear and result-valid strobes for the 16-PE array, and the comparator enable with its candidate motion vector. It sits inside `top` between the start/completed handshake and the PE array and comparator.

## Interface
- none: geometry is fixed at 16 PEs, a 16x16 block, and a 32-column search-memory pitch.

- clock  in  1  system clock; all state changes on rising edge
- reset  in  1  synchronous, active-high; overrides every other input
- start  in  1  level request; sampled only in IDLE
- AddressR  out  8  reference-memory address
- AddressS1  out  10  search-memory address, left half
- AddressS2  out  10  search-memory address, right half
- S1S2mux  out  16  bit k=1: PE k takes S1, bit k=0: PE k takes S2
- NewDist  out  16  bit k: PE k restarts its accumulation this cycle
- PEready  out  16  bit k: PE k distance valid this cycle
- CompStart  out  1  comparator evaluates the PEready distance this cycle
- VectorX  out  4  candidate horizontal offset (valid with CompStart)
- VectorY  out  4  candidate vertical offset (valid with CompStart)
- busy  out  1  state == RUN
- completed  out  1  state == DONE

## Operation
- Registers: 2-bit state (IDLE, RUN, DONE) and a 13-bit count. All outputs are combinational decodes of these registers; there are no extra pipeline stages.
- Field split of count: y = count[11:8], i = count[7:4], j = count[3:0].
- IDLE:
  - count = 0; every output is 0.
  - start=1 → RUN with count=0.
- RUN:
  - count increments by 1 each cycle.
  - At count==4111, next state is DONE and count holds 4111.
  - start is ignored.
- DONE:
  - completed=1; all other outputs are 0.
  - Stays in DONE while start=1.
  - start=0 → IDLE and count is cleared.
- Decodes in RUN (all are 0 outside RUN except completed):
  - AddressR = count[7:0].
  - AddressS1 = (y+i)*32 + j, computed at 10 bits. The maximum is 975, so there is no overflow.
  - AddressS2 = AddressS1 + 16. The maximum is 991.
  - S1S2mux[k] = (j >= k). Bit 0 is always 1 in RUN.
  - NewDist[k] = (count[7:0] == k).
  - PEready[k] = (count[7:0] == k) && (count >= 256).
  - CompStart = OR of PEready.
  - VectorX = j when CompStart, else 0.
  - VectorY = (y − 1) mod 16 when CompStart, else 0. In the tail counts 4096..4111, y=0, so VectorY=15.
- Tail counts 4096..4111 only drain PE results. The address outputs still follow the formulas above; their values are don't-care to the datapath.
- Reset mid-RUN or mid-DONE: state goes to IDLE and count to 0 at that edge, and all outputs drop to 0 in the following cycle. No partial completion is ever signalled.

## Timing
- Call the edge that samples start=1 in IDLE E0. RUN begins with count=0 after E0.
- RUN lasts exactly 4112 cycles (count 0..4111).
- completed rises after edge E0+4112.
- The first PEready/CompStart is at count 256 (PE 0, vector 0,0).
- CompStart is high for 16 consecutive cycles at every count with count ≥ 256 and i==0, giving 256 assertions in total.
- Each CompStart presents exactly one PEready bit, so the comparator sees one candidate per cycle.
- Back-to-back runs: start must be low for at least one cycle in DONE. The earliest restart is two edges after completed rises.

## Test plan
- Reset check:
  - Stimulus: assert reset for 3 cycles with start=1.
  - Required: busy, completed and all vectors/addresses stay 0. On release, RUN starts the next edge.
- Full run, start held high (as top_tb drives it):
  - Required: busy for exactly 4112 cycles; completed rises at E0+4112 and stays 1 for 100 cycles; CompStart count is exactly 256.
- Address decode:
  - At count 0x123: AddressR=0x23, AddressS1=99, AddressS2=115, S1S2mux=16'h000F.
  - At count 0xFFF: AddressS1=975, AddressS2=991.
- Strobe decode:
  - At count 256: PEready=16'h0001, NewDist=16'h0001, VectorX=0, VectorY=0.
  - At count 0x52A: PEready=0, NewDist=0.
  - At count 4111: PEready=16'h8000, VectorX=15, VectorY=15.
- Reset mid-run:
  - Stimulus: assert reset at count 2000.
  - Required: the next cycle is IDLE with all outputs 0. A subsequent start gives a full 4112-cycle run.
- Restart:
  - Stimulus: drop start for 1 cycle in DONE, then raise it.
  - Required: completed falls, and a second run starts with AddressS1=0 and behaves identically to the first.
